// File: rtl/load_store_sched_if.sv
// load_store_sched_if
//   Requester-side bundle for the load/store scheduler. The four requesters
//   drive req/dir/len. The scheduler returns grant and completion status
//   along with the shared volume.
//
//   req   [3:0]          request per requester, held until its done pulse
//   dir   [3:0]          1 = fill, 0 = drain (sampled at grant)
//   len   [4*LBITS-1:0]  units per requester, requester i at [i*LBITS +: LBITS]
//   gnt   [3:0]          one-hot grant
//   done  [3:0]          one-cycle completion pulse
//   trunc                transfer ended short of len (valid with done)
//   vol   [CBITS-1:0]    current volume
//   full / empty         vol == N / vol == 0
interface load_store_sched_if #(
   parameter int CBITS = 16,
   parameter int LBITS = 8
);
   logic [3:0]         req;
   logic [3:0]         dir;
   logic [4*LBITS-1:0] len;
   logic [3:0]         gnt;
   logic [3:0]         done;
   logic               trunc;
   logic [CBITS-1:0]   vol;
   logic               full;
   logic               empty;

   modport master (
      output req, dir, len,
      input  gnt, done, trunc, vol, full, empty
   );

   modport slave (
      input  req, dir, len,
      output gnt, done, trunc, vol, full, empty
   );
endinterface

// File: rtl/load_store_sched.sv
// load_store_sched
//   Round-robin scheduler for one shared load/store volume register. Four
//   requesters take turns. The granted requester fills or drains the volume
//   by one unit per cycle, up to its requested length. The volume clamps at
//   0 and N.
//
//   Ports:
//     i_clk      clock, rising edge
//     i_rst      synchronous active-high reset
//     sched_bus  load_store_sched_if.slave: req/dir/len in,
//                gnt/done/trunc/vol/full/empty out
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; arbitrate among eligible requesters each edge
//   XFER  | owner granted; step vol by one unit per edge until finished
//   DONE  | done pulse and final gnt cycle; return to IDLE on next edge
module load_store_sched #(
   parameter int N     = 50000,
   parameter int CBITS = 16,
   parameter int LBITS = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   load_store_sched_if.slave  sched_bus
);

   localparam logic [CBITS-1:0] VOL_MAX = CBITS'(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CBITS-1:0]  r_vol,   w_vol_nxt;
   logic [1:0]        r_ptr,   w_ptr_nxt;
   logic [1:0]        r_owner, w_owner_nxt;
   logic              r_dir,   w_dir_nxt;
   logic [LBITS-1:0]  r_rem,   w_rem_nxt;
   logic [3:0]        r_gnt,   w_gnt_nxt;
   logic [3:0]        r_done,  w_done_nxt;
   logic              r_trunc, w_trunc_nxt;

   logic [3:0]        w_elig;
   logic              w_win_vld;
   logic [1:0]        w_win_idx;
   logic [1:0]        w_cand;
   logic [LBITS-1:0]  w_win_len;
   logic              w_at_limit;

   // Requests that cannot move the volume stay pending and do not compete.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < 4; i++) begin
         w_elig[i] = sched_bus.req[i] &
                     (sched_bus.dir[i] ? (r_vol < VOL_MAX) : (r_vol != '0));
      end
   end

   // Scan from the farthest offset back to ptr so the nearest eligible
   // requester is the last one written and therefore wins.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = r_ptr;
      w_cand    = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_cand = r_ptr + 2'(k);
         if (w_elig[w_cand]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_cand;
         end
      end
   end

   assign w_win_len  = sched_bus.len[w_win_idx*LBITS +: LBITS];
   assign w_at_limit = r_dir ? (r_vol == VOL_MAX) : (r_vol == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_vol_nxt   = r_vol;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_dir_nxt   = r_dir;
      w_rem_nxt   = r_rem;
      w_gnt_nxt   = r_gnt;
      w_done_nxt  = r_done;
      w_trunc_nxt = r_trunc;

      case (r_state)
         IDLE: begin
            w_gnt_nxt   = '0;
            w_done_nxt  = '0;
            w_trunc_nxt = 1'b0;
            if (w_win_vld) begin
               w_state_nxt = XFER;
               w_gnt_nxt   = 4'(1) << w_win_idx;
               w_owner_nxt = w_win_idx;
               w_dir_nxt   = sched_bus.dir[w_win_idx];
               w_rem_nxt   = w_win_len;
               w_ptr_nxt   = w_win_idx + 2'd1;
            end
         end

         XFER: begin
            // Abort wins over normal completion, which wins over clamping.
            if (!sched_bus.req[r_owner]) begin
               w_state_nxt = DONE;
               w_done_nxt  = 4'(1) << r_owner;
               w_trunc_nxt = 1'b1;
            end else if (r_rem == '0) begin
               w_state_nxt = DONE;
               w_done_nxt  = 4'(1) << r_owner;
               w_trunc_nxt = 1'b0;
            end else if (w_at_limit) begin
               w_state_nxt = DONE;
               w_done_nxt  = 4'(1) << r_owner;
               w_trunc_nxt = 1'b1;
            end else begin
               w_vol_nxt = r_dir ? (r_vol + CBITS'(1)) : (r_vol - CBITS'(1));
               w_rem_nxt = r_rem - LBITS'(1);
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_done_nxt  = '0;
            w_trunc_nxt = 1'b0;
         end

         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_done_nxt  = '0;
            w_trunc_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_vol   <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
         r_dir   <= 1'b0;
         r_rem   <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_trunc <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vol   <= w_vol_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_dir   <= w_dir_nxt;
         r_rem   <= w_rem_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
         r_trunc <= w_trunc_nxt;
      end
   end

   assign sched_bus.gnt   = r_gnt;
   assign sched_bus.done  = r_done;
   assign sched_bus.trunc = r_trunc;
   assign sched_bus.vol   = r_vol;
   assign sched_bus.full  = (r_vol == VOL_MAX);
   assign sched_bus.empty = (r_vol == '0);

endmodule

// File: tb/tb_load_store_sched.sv
// Bench for load_store_sched with N = 10. It runs directed scenarios that
// check literal values, then random traffic. A transaction-level model
// shadows the DUT, and the DUT outputs are compared against it on every
// falling edge.
module tb_load_store_sched;
   localparam int N     = 10;
   localparam int CBITS = 16;
   localparam int LBITS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_sched_if #(.CBITS(CBITS), .LBITS(LBITS)) bus ();

   load_store_sched #(.N(N), .CBITS(CBITS), .LBITS(LBITS)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .sched_bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int         m_vol;
   int         m_ptr;
   logic [3:0] e_gnt;
   logic [3:0] e_done;
   logic       e_trunc;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // The model is written as one transaction per loop pass: wait for a
   // winner, run the transfer, then emit the done cycle. A reset edge
   // abandons the transaction.
   task automatic run_model();
      int w, L, moved;
      bit d, tr;
      forever begin
         @(posedge clk);
         if (rst) return;
         w = -1;
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (w < 0 && bus.req[i] && (bus.dir[i] ? (m_vol < N) : (m_vol > 0)))
               w = i;
         end
         if (w < 0) continue;
         m_ptr = (w + 1) % 4;
         d     = bus.dir[w];
         L     = int'(bus.len[w*LBITS +: LBITS]);
         moved = 0;
         tr    = 1'b0;
         e_gnt = 4'(1 << w);
         forever begin
            @(posedge clk);
            if (rst) return;
            if (!bus.req[w]) begin tr = 1'b1; break; end
            if (moved == L) break;
            if (d ? (m_vol == N) : (m_vol == 0)) begin tr = 1'b1; break; end
            m_vol = d ? m_vol + 1 : m_vol - 1;
            moved++;
         end
         e_done  = e_gnt;
         e_trunc = tr;
         @(posedge clk);
         if (rst) return;
         e_gnt   = '0;
         e_done  = '0;
         e_trunc = 1'b0;
      end
   endtask

   initial begin
      forever begin
         m_vol   = 0;
         m_ptr   = 0;
         e_gnt   = '0;
         e_done  = '0;
         e_trunc = 1'b0;
         run_model();
      end
   end

   always @(negedge clk) begin
      chk("gnt",     32'(bus.gnt),   32'(e_gnt));
      chk("done",    32'(bus.done),  32'(e_done));
      chk("trunc",   32'(bus.trunc), 32'(e_trunc));
      chk("vol",     32'(bus.vol),   32'(m_vol));
      chk("full",    32'(bus.full),  32'(m_vol == N));
      chk("empty",   32'(bus.empty), 32'(m_vol == 0));
      chk("gnt_oh",  32'($onehot0(bus.gnt)), 32'd1);
   end

   task automatic raise(int i, bit d, int l);
      bus.req[i] = 1'b1;
      bus.dir[i] = d;
      bus.len[i*LBITS +: LBITS] = LBITS'(l);
   endtask

   task automatic wait_done(int i, output bit tr);
      int cyc;
      cyc = 0;
      tr  = 1'b0;
      while (bus.done[i] !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", 32'(bus.done[i]), 32'd1);
      tr = bus.trunc;
      bus.req[i] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit tr;
      int cyc;
      bus.req = '0;
      bus.dir = '0;
      bus.len = '0;

      // Fill 4 units from empty
      do_reset();
      chk("rst_vol",   32'(bus.vol),   32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full",  32'(bus.full),  32'd0);
      raise(0, 1'b1, 4);
      @(negedge clk);
      chk("t1_gnt", 32'(bus.gnt), 32'h1);
      chk("t1_vol0", 32'(bus.vol), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t1_vol", 32'(bus.vol), 32'(k));
         chk("t1_empty", 32'(bus.empty), 32'd0);
      end
      @(negedge clk);
      chk("t1_done", 32'(bus.done), 32'h1);
      chk("t1_trunc", 32'(bus.trunc), 32'd0);
      bus.req[0] = 1'b0;
      @(negedge clk);
      chk("t1_idle_gnt", 32'(bus.gnt), 32'h0);

      // Fill to 8, then clamp at full
      raise(1, 1'b1, 4);
      wait_done(1, tr);
      chk("t2_vol8", 32'(bus.vol), 32'd8);
      @(negedge clk);
      raise(1, 1'b1, 5);
      wait_done(1, tr);
      chk("t2_trunc", 32'(tr), 32'd1);
      chk("t2_vol10", 32'(bus.vol), 32'd10);
      chk("t2_full", 32'(bus.full), 32'd1);

      // Drain exactly to 0; len equal to vol ends without truncation
      @(negedge clk);
      raise(0, 1'b0, 10);
      wait_done(0, tr);
      chk("t3_drain_trunc", 32'(tr), 32'd0);
      chk("t3_vol0", 32'(bus.vol), 32'd0);
      @(negedge clk);
      raise(2, 1'b0, 3);
      repeat (5) begin
         @(negedge clk);
         chk("t3_no_gnt", 32'(bus.gnt), 32'h0);
      end
      raise(0, 1'b1, 2);
      wait_done(0, tr);
      chk("t3_vol2", 32'(bus.vol), 32'd2);
      wait_done(2, tr);
      chk("t3_r2_trunc", 32'(tr), 32'd1);
      chk("t3_r2_vol", 32'(bus.vol), 32'd0);

      // Round-robin order with all four requesting
      do_reset();
      for (int i = 0; i < 4; i++) raise(i, 1'b1, 1);
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         while (bus.done == 4'h0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
         end
         chk("t4_rr_order", 32'(bus.done), 32'(1 << k));
         bus.req = bus.req & ~bus.done;
         @(negedge clk);
         chk("t4_done_width", 32'(bus.done), 32'h0);
      end
      chk("t4_vol", 32'(bus.vol), 32'd4);

      // Abort after two steps
      do_reset();
      raise(3, 1'b1, 10);
      @(negedge clk);
      chk("t5_gnt", 32'(bus.gnt), 32'h8);
      @(negedge clk);
      chk("t5_vol1", 32'(bus.vol), 32'd1);
      @(negedge clk);
      chk("t5_vol2", 32'(bus.vol), 32'd2);
      bus.req[3] = 1'b0;
      @(negedge clk);
      chk("t5_done", 32'(bus.done), 32'h8);
      chk("t5_trunc", 32'(bus.trunc), 32'd1);
      chk("t5_vol", 32'(bus.vol), 32'd2);
      @(negedge clk);
      chk("t5_idle", 32'(bus.gnt), 32'h0);

      // Reset in the middle of a transfer
      do_reset();
      raise(1, 1'b1, 9);
      cyc = 0;
      while (bus.vol != CBITS'(5) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("t6_reach5", 32'(bus.vol), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_vol", 32'(bus.vol), 32'd0);
      chk("t6_gnt", 32'(bus.gnt), 32'h0);
      chk("t6_done", 32'(bus.done), 32'h0);
      chk("t6_empty", 32'(bus.empty), 32'd1);
      rst = 1'b0;
      raise(0, 1'b1, 1);
      @(negedge clk);
      chk("t6_ptr0", 32'(bus.gnt), 32'h1);
      wait_done(0, tr);
      @(negedge clk);
      wait_done(1, tr);

      // Random traffic
      do_reset();
      repeat (4000) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && bus.done[i])
               bus.req[i] = 1'b0;
            else if (!bus.req[i] && $urandom_range(0, 3) == 0)
               raise(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 14)));
            else if (bus.req[i] && !bus.gnt[i] && $urandom_range(0, 60) == 0)
               bus.req[i] = 1'b0;
            else if (bus.req[i] && bus.gnt[i] && !bus.done[i] && $urandom_range(0, 40) == 0)
               bus.req[i] = 1'b0;
         end
         rst = ($urandom_range(0, 400) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_sched.md
# load_store_sched

Round-robin scheduler that shares a single load/store volume register among four requesters. Each requester asks to fill (load) or drain (store) the volume by a length. The block grants one requester at a time and steps the volume by one unit per cycle, clamping at 0 and N. It reports completion and truncation per transfer and is the sequencing layer in front of the volume/level datapath.

## Interface
- N, 50000: full-scale volume; must be < 2^CBITS.
- CBITS, 16: volume width.
- LBITS, 8: per-requester length width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  4  request per requester; held until that requester's done pulse.
- dir  in  4  direction per requester: 1 = fill (+1/cycle), 0 = drain (-1/cycle); sampled at grant.
- len  in  4*LBITS  requested units per requester, packed (requester i at [i*LBITS +: LBITS]); sampled at grant.
- gnt  out  4  one-hot grant, registered; high from XFER entry through the DONE cycle.
- done  out  4  one-cycle completion pulse for the granted requester.
- trunc  out  1  valid with done: 1 if the transfer ended before len units.
- vol  out  CBITS  current volume, registered.
- full  out  1  vol == N.
- empty  out  1  vol == 0.

## Operation
- States: IDLE, XFER, DONE. Registers: vol, state, rr pointer (2 bits), owner index, latched dir, remaining count rem (LBITS), gnt, done, trunc.
- Eligibility in IDLE: requester i is eligible if req[i] and (dir[i] ? vol < N : vol > 0). Ineligible requests stay pending. They are not dropped and not acknowledged.
- Arbitration: first eligible index scanning ptr, ptr+1, ... mod 4. On grant to i, ptr <= i+1 mod 4.
- IDLE with an eligible requester at an edge: state <= XFER, gnt <= onehot(i), rem <= len[i], latch dir[i].
- IDLE with no eligible requester: stay in IDLE; gnt = 0.
- XFER, evaluated in priority order each edge:
  - req[owner] == 0 (abort): go to DONE with trunc = 1.
  - rem == 0: go to DONE with trunc = 0.
  - Fill and vol == N, or drain and vol == 0: go to DONE with trunc = 1.
  - Otherwise: vol ± 1 and rem - 1.
- DONE: done[owner] = 1 and gnt still asserted for exactly this cycle. At the next edge, clear gnt, done and trunc and return to IDLE. Arbitration restarts from that IDLE cycle.
- len = 0: zero volume change; done with trunc = 0.
- vol never exceeds N and never wraps below 0.
- full and empty are combinational from the vol register.

## Timing
- Reset values: state = IDLE, vol = 0, ptr = 0, gnt = 0, done = 0, trunc = 0. Therefore full = 0 (N > 0) and empty = 1.
- Reset mid-transfer: the next edge forces the reset values. No done pulse is issued for the lost transfer.
- Grant edge t0: gnt is high from cycle t0+1.
- Unclamped transfer of L units: vol changes at edges t0+1 through t0+L. DONE is entered at edge t0+L+1. done is high in cycle t0+L+1 to t0+L+2. IDLE returns at edge t0+L+2.
- Minimum spacing between grants: 3 edges (grant, XFER≥1, DONE).
- Volume changes by at most 1 per cycle and only in XFER.
- Inputs other than req are don't-care outside the grant edge.

## Test plan
- N=10, reset, then req[0]=1, dir=fill, len=4 -> gnt[0] from t0+1. vol steps 1,2,3,4. done[0] at t0+5 with trunc=0. empty falls after the first step.
- N=10, vol=8, req[1] fill len=5 -> vol 9,10, then DONE with trunc=1. full=1, vol holds 10 and never reaches 11.
- vol=0, req[2] drain len=3 -> never granted while vol=0. Raise req[0] fill len=2 -> requester 0 serviced, vol=2. Requester 2 then granted, drains 2, done with trunc=1, vol=0.
- All four req high (fills, len=1) with ptr=0 -> grants in order 0,1,2,3. Each done pulse is 1 cycle wide, and every gnt is one-hot.
- req[3] fill len=10 and req[3] dropped after 2 steps -> vol=2, done[3] with trunc=1, then IDLE.
- Assert rst during XFER at vol=5 -> next cycle vol=0, gnt=0, done=0, empty=1. Arbitration resumes from ptr=0.
